// File: rtl/wb_stage_pkg.sv
// Shared constants and the load alignment function for the write-back stage.
package wb_stage_pkg;

    // Bit positions of the one-hot align_load vector.
    localparam int unsigned AlignLw  = 6;
    localparam int unsigned AlignLb  = 5;
    localparam int unsigned AlignLbu = 4;
    localparam int unsigned AlignLh  = 3;
    localparam int unsigned AlignLhu = 2;
    localparam int unsigned AlignLwl = 1;
    localparam int unsigned AlignLwr = 0;

    // Bit positions of the one-hot rf_wdata_src vector.
    localparam int unsigned SrcAlu  = 0;
    localparam int unsigned SrcLoad = 1;
    localparam int unsigned SrcPc8  = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu_res;
        logic [31:0] rf_b;
        logic [4:0]  waddr;
        logic [2:0]  src;
        logic        wen;
        logic        mem_read;
        logic [6:0]  align;
    } wb_instr_t;

    function automatic logic [31:0] load_align(input logic [6:0]  align,
                                               input logic [1:0]  off,
                                               input logic [31:0] d,
                                               input logic [31:0] b);
        logic [31:0] sh_b;
        logic [31:0] sh_h;
        logic [7:0]  by;
        logic [15:0] hw;
        logic [31:0] res;
        sh_b = d >> {off, 3'b000};
        sh_h = d >> {off[1], 4'b0000};
        by   = sh_b[7:0];
        hw   = sh_h[15:0];
        res  = d;
        if (align[AlignLb]) begin
            res = {{24{by[7]}}, by};
        end else if (align[AlignLbu]) begin
            res = {24'h0, by};
        end else if (align[AlignLh]) begin
            res = {{16{hw[15]}}, hw};
        end else if (align[AlignLhu]) begin
            res = {16'h0, hw};
        end else if (align[AlignLwl]) begin
            unique case (off)
                2'd0: res = {d[7:0], b[23:0]};
                2'd1: res = {d[15:0], b[15:0]};
                2'd2: res = {d[23:0], b[7:0]};
                2'd3: res = d;
            endcase
        end else if (align[AlignLwr]) begin
            unique case (off)
                2'd0: res = d;
                2'd1: res = {b[31:24], d[31:8]};
                2'd2: res = {b[31:16], d[31:16]};
                2'd3: res = {b[31:8], d[31:24]};
            endcase
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_stage_load_align_unit.sv
// Combinational extract/extend/merge of registered load data.
module load_align_unit
    import wb_stage_pkg::*;
(
    input  logic [6:0]  align_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] data_i,
    input  logic [31:0] rf_b_i,
    output logic [31:0] result_o
);

    always_comb begin
        result_o = load_align(align_i, off_i, data_i, rf_b_i);
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: holds one instruction, waits for load data, aligns it and
// commits the result to the register file.
module wb_stage
    import wb_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_p,
    input  logic        MA_ready,
    output logic        WB_enable,
    input  logic [31:0] rf_B_in,
    input  logic [4:0]  rf_waddr_in,
    input  logic [2:0]  rf_wdata_src_in,
    input  logic        rf_wen_in,
    input  logic [31:0] alu_res_in,
    input  logic        mem_read_in,
    input  logic [6:0]  align_load_in,
    input  logic [31:0] MA_PC,
    input  logic        mem_rdata_valid,
    input  logic [31:0] mem_rdata,
    output logic        rf_wen,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        valid_out,
    output logic        load_pending,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
);

    logic        valid_q, valid_d;
    logic        has_data_q, has_data_d;
    wb_instr_t   instr_q, instr_d;
    logic [31:0] rdata_q, rdata_d;

    logic        leaving;
    logic        comming;
    logic        waiting;
    logic [31:0] load_value;

    // Everything below depends only on registers, keeping mem_rdata_valid
    // out of the upstream stall path.
    assign waiting   = valid_q && instr_q.mem_read && !has_data_q;
    assign leaving   = valid_q && (!instr_q.mem_read || has_data_q);
    assign WB_enable = !valid_q || leaving;
    assign comming   = WB_enable && MA_ready;

    always_comb begin
        valid_d    = valid_q;
        has_data_d = has_data_q;
        instr_d    = instr_q;
        rdata_d    = rdata_q;
        if (leaving) begin
            valid_d    = 1'b0;
            has_data_d = 1'b0;
        end
        if (comming) begin
            valid_d          = 1'b1;
            has_data_d       = 1'b0;
            instr_d.pc       = MA_PC;
            instr_d.alu_res  = alu_res_in;
            instr_d.rf_b     = rf_B_in;
            instr_d.waddr    = rf_waddr_in;
            instr_d.src      = rf_wdata_src_in;
            instr_d.wen      = rf_wen_in;
            instr_d.mem_read = mem_read_in;
            instr_d.align    = align_load_in;
        end else if (waiting && mem_rdata_valid) begin
            has_data_d = 1'b1;
            rdata_d    = mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_p) begin
            valid_q    <= 1'b0;
            has_data_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            has_data_q <= has_data_d;
        end
    end

    // Payload registers are qualified by valid_q, so they carry no reset.
    always_ff @(posedge clk) begin
        instr_q <= instr_d;
        rdata_q <= rdata_d;
    end

    load_align_unit u_load_align (
        .align_i  (instr_q.align),
        .off_i    (instr_q.alu_res[1:0]),
        .data_i   (rdata_q),
        .rf_b_i   (instr_q.rf_b),
        .result_o (load_value)
    );

    always_comb begin
        rf_wdata = instr_q.alu_res;
        if (instr_q.src[SrcLoad]) begin
            rf_wdata = load_value;
        end else if (instr_q.src[SrcPc8]) begin
            rf_wdata = instr_q.pc + 32'd8;
        end
    end

    assign rf_wen            = leaving && instr_q.wen && (instr_q.waddr != 5'd0);
    assign rf_waddr          = instr_q.waddr;
    assign valid_out         = valid_q;
    assign load_pending      = waiting;
    assign debug_wb_pc       = instr_q.pc;
    assign debug_wb_rf_wen   = {4{rf_wen}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage: final pipeline stage, directly downstream of the memory-access stage. Accepts one instruction at a time over the valid/enable/ready handshake and waits for the read response of an in-flight load. Aligns and sign/zero-extends load data, including the lwl/lwr merge with the old rt value, and commits the result to the register file. Load data is registered before commit, so no combinational path runs from the memory response to the upstream stall logic.

## Interface
- No parameters.
- `clk`  in  1  clock. One clock domain.
- `rst_p`  in  1  reset. Synchronous, active-high.
- `MA_ready`  in  1  upstream holds a valid instruction able to leave.
- `WB_enable`  out  1  stage can accept this cycle.
- `rf_B_in`  in  32  old rt value, used for lwl/lwr merge.
- `rf_waddr_in`  in  5  destination register.
- `rf_wdata_src_in`  in  3  one-hot source: [0] alu_res, [1] load data, [2] PC+8.
- `rf_wen_in`  in  1  instruction writes the register file.
- `alu_res_in`  in  32  ALU, HI/LO or CP0 result; for loads, the effective address.
- `mem_read_in`  in  1  instruction is a load whose request was issued.
- `align_load_in`  in  7  one-hot: [6] lw, [5] lb, [4] lbu, [3] lh, [2] lhu, [1] lwl, [0] lwr.
- `MA_PC`  in  32  PC of the incoming instruction.
- `mem_rdata_valid`  in  1  single-cycle read-response strobe.
- `mem_rdata`  in  32  aligned word read data.
- `rf_wen`  out  1  register-file write strobe.
- `rf_waddr`  out  5  write address.
- `rf_wdata`  out  32  write data.
- `valid_out`  out  1  stage holds an instruction (to forward unit).
- `load_pending`  out  1  held instruction is a load without data yet; forward unit must stall rather than forward.
- `debug_wb_pc`  out  32  trace: PC of the committing instruction.
- `debug_wb_rf_wen`  out  4  trace: `{4{rf_wen}}`.
- `debug_wb_rf_wnum`  out  5  trace: write address.
- `debug_wb_rf_wdata`  out  32  trace: write data.

## Operation
- Handshake signals:
  - comming = `WB_enable && MA_ready`.
  - `leaving` = valid && (!mem_read || has_data).
  - `WB_enable` = !valid || `leaving`.
- State is encoded by {valid, has_data}:
  - EMPTY → no instruction held.
  - WAIT: a load without data.
  - READY: non-load, or a load with captured data.
- Transitions:
  - On comming, all `*_in` fields and `MA_PC` are latched and has_data is cleared. The state becomes READY if `!mem_read_in`, otherwise WAIT.
  - In WAIT, `mem_rdata_valid` latches `mem_rdata` into the data register and sets has_data, moving to READY.
  - READY always leaves in the same cycle.
  - A simultaneous leave and comming replaces the held instruction without a bubble.
  - With no comming on leave, the state returns to EMPTY.
- `mem_rdata_valid` outside WAIT is ignored and must not change any state; the bench flags it as a protocol error.
- Load alignment uses off = alu_res[1:0], d = data register, b = rf_B:
  - lw → d.
  - lb/lbu → byte d[8·off+7:8·off], sign- or zero-extended.
  - lh/lhu → half d[16·alu_res[1]+15 : 16·alu_res[1]], sign- or zero-extended.
  - lwl by off: 0 {d[7:0],b[23:0]}, 1 {d[15:0],b[15:0]}, 2 {d[23:0],b[7:0]}, 3 d.
  - lwr by off: 0 d, 1 {b[31:24],d[31:8]}, 2 {b[31:16],d[31:16]}, 3 {b[31:8],d[31:24]}.
- rf_wdata is selected by src: alu_res, the aligned load value, or PC+8 (32-bit add, wraps modulo 2^32).
- `rf_wen` = `leaving && rf_wen_reg && rf_waddr != 0`. `rf_waddr` and `rf_wdata` are driven from the held instruction.
- Debug outputs mirror the rf outputs; `debug_wb_pc` is the held PC.

## Timing
- Reset values:
  - valid=0 and has_data=0.
  - `WB_enable`=1; `rf_wen`, `valid_out`, `load_pending` and `debug_wb_rf_wen` are 0.
  - Data registers are not reset; their outputs are qualified by valid.
- Reset mid-load: the pending response is dropped; a later strobe is ignored because the stage is not in WAIT.
- Non-load latency: one cycle in WB; commits in the cycle after comming.
- Load latency: the response arrives at least one cycle after comming (the request is issued in the comming cycle). Commit is one cycle after the `mem_rdata_valid` cycle.
- `WB_enable` and `rf_wen` depend only on registers, never on `mem_rdata_valid`.
- `load_pending` = valid && mem_read && !has_data.

## Structure
- Shared package holds the constants below and the alignment function:
  - Bit indices of `align_load` and `rf_wdata_src`.
  - The `load_align(align, off, d, b)` function, shared with any future load-forwarding logic.
- One sub-module, `load_align_unit`, holds the combinational extract/extend/merge; the stage holds the handshake, state and registers.

## Test plan
- Back-to-back ALU writes: addu to r3 with alu_res 0x12345678, then one to r4 → rf_wen on consecutive cycles; WB_enable stays 1; no bubble.
- lb, off=3, response 0x80AABBCC two cycles after entry:
  - load_pending=1 and WB_enable=0 during the wait.
  - Commit of 0xFFFFFF80 one cycle after the strobe.
- lwl off=1, rf_B=0x11223344, data 0xAABBCCDD → 0xCCDD3344; lwr off=2, same inputs → 0x1122AABB.
- Link instruction, PC 0xFFFFFFFC, src=PC+8 → wdata 0x00000004. Write to r0 → rf_wen=0, but the trace still shows the PC.
- Stray `mem_rdata_valid` while EMPTY and during a non-load → no state change, no write.
- rst_p asserted while in WAIT, then a strobe the following cycle → valid=0, no write, WB_enable=1.
